alu_share_arbiter: RTL and testbench

//  Shares the single combinational 8-bit ALU between two requesters (req0, req1),
//  e.g. execute stage and address/branch unit. Round-robin grant; valid/ready

---
 rtl/alu_share_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Operands and results are registered; a single transaction is in flight at a time.
module alu_share_arbiter #(
   parameter int W   = 8,
   parameter int OPW = 3
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic [OPW-1:0] req0_op,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   input  logic [OPW-1:0] req1_op,
   output logic           rsp0_valid,
   input  logic           rsp0_ready,
   output logic           rsp1_valid,
   input  logic           rsp1_ready,
   output logic [W-1:0]   rsp_out,
   output logic           rsp_eq,
   output logic           rsp_lt,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   output logic [OPW-1:0] alu_op,
   input  logic [W-1:0]   alu_out,
   input  logic           alu_eq,
   input  logic           alu_lt
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e         state_q, state_d;
   logic           last_grant_q, last_grant_d;
   logic           owner_q, owner_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [OPW-1:0] op_q, op_d;
   logic [W-1:0]   res_q, res_d;
   logic           eq_q, eq_d;
   logic           lt_q, lt_d;
   logic           rsp0_valid_q, rsp0_valid_d;
   logic           rsp1_valid_q, rsp1_valid_d;

   logic           grant0, grant1;
   logic           acc0, acc1;
   logic           rsp_take;

   always_comb begin
      // A tie goes to the requester that was not served last.
      grant0     = req0_valid & (~req1_valid | last_grant_q);
      grant1     = req1_valid & (~req0_valid | ~last_grant_q);
      req0_ready = (state_q == IDLE) & ~Reset & grant0;
      req1_ready = (state_q == IDLE) & ~Reset & grant1;
      acc0       = req0_valid & req0_ready;
      acc1       = req1_valid & req1_ready;
      rsp_take   = owner_q ? rsp1_ready : rsp0_ready;

      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      res_d        = res_q;
      eq_d         = eq_q;
      lt_d         = lt_q;
      rsp0_valid_d = rsp0_valid_q;
      rsp1_valid_d = rsp1_valid_q;

      case (state_q)
         IDLE: begin
            if (acc0) begin
               a_d          = req0_a;
               b_d          = req0_b;
               op_d         = req0_op;
               owner_d      = 1'b0;
               last_grant_d = 1'b0;
               state_d      = EXEC;
            end else if (acc1) begin
               a_d          = req1_a;
               b_d          = req1_b;
               op_d         = req1_op;
               owner_d      = 1'b1;
               last_grant_d = 1'b1;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            res_d        = alu_out;
            eq_d         = alu_eq;
            lt_d         = alu_lt;
            rsp0_valid_d = ~owner_q;
            rsp1_valid_d = owner_q;
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_take) begin
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         res_q        <= '0;
         eq_q         <= 1'b0;
         lt_q         <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         res_q        <= res_d;
         eq_q         <= eq_d;
         lt_q         <= lt_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
      end
   end

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_op     = op_q;
   assign rsp_out    = res_q;
   assign rsp_eq     = eq_q;
   assign rsp_lt     = lt_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios followed by a randomized run
// checked against a transaction-level reference model with a response scoreboard.
module tb_alu_share_arbiter;

   localparam int W   = 8;
   localparam int OPW = 3;

   localparam logic [2:0] mcADD = 3'd0;
   localparam logic [2:0] mcSUB = 3'd1;
   localparam logic [2:0] mcAND = 3'd2;
   localparam logic [2:0] mcOR  = 3'd3;
   localparam logic [2:0] mcXOR = 3'd4;
   localparam logic [2:0] mcNOT = 3'd5;
   localparam logic [2:0] mcLSL = 3'd6;
   localparam logic [2:0] mcLSR = 3'd7;

   logic           Clk, Reset;
   logic           req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
   logic [OPW-1:0] req0_op, req1_op;
   logic           rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [W-1:0]   rsp_out;
   logic           rsp_eq, rsp_lt;
   logic [W-1:0]   alu_a, alu_b, alu_out;
   logic [OPW-1:0] alu_op;
   logic           alu_eq, alu_lt;

   alu_share_arbiter #(.W(W), .OPW(OPW)) dut (
      .Clk(Clk), .Reset(Reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_out(rsp_out), .rsp_eq(rsp_eq), .rsp_lt(rsp_lt),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_out(alu_out), .alu_eq(alu_eq), .alu_lt(alu_lt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // {result, EQUALS, LT} of the 8-bit ALU for one operand set
   function automatic logic [9:0] alu_eval(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
      logic [7:0] r;
      case (op)
         mcADD:   r = a + b;
         mcSUB:   r = a - b;
         mcAND:   r = a & b;
         mcOR:    r = a | b;
         mcXOR:   r = a ^ b;
         mcNOT:   r = ~a;
         mcLSL:   r = a << b;
         mcLSR:   r = a >> b;
         default: r = 8'h00;
      endcase
      return {r, a == b, a < b};
   endfunction

   // The shared ALU the arbiter drives
   always_comb {alu_out, alu_eq, alu_lt} = alu_eval(alu_a, alu_b, alu_op);

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive_req(input int p, input logic v, input logic [7:0] a,
                            input logic [7:0] b, input logic [2:0] op);
      if (p == 0) begin
         req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
      end else begin
         req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      drive_req(0, 1'b0, 8'h00, 8'h00, mcADD);
      drive_req(1, 1'b0, 8'h00, 8'h00, mcADD);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      tick();
      tick();
      Reset = 1'b0;
   endtask

   // Called one cycle after acceptance (EXEC): checks the response, then takes it.
   task automatic expect_rsp(input string tag, input int p, input logic [9:0] e);
      tick();
      chk({tag, "_rspv"}, {rsp1_valid, rsp0_valid}, (p == 0) ? 2'b01 : 2'b10);
      chk({tag, "_data"}, {rsp_out, rsp_eq, rsp_lt}, e);
      if (p == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
   endtask

   // Single uncontended transaction from IDLE
   task automatic run_one(input string tag, input int p, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] op);
      drive_req(p, 1'b1, a, b, op);
      #1;
      chk({tag, "_ready"}, (p == 0) ? req0_ready : req1_ready, 1);
      tick();
      drive_req(p, 1'b0, 8'h00, 8'h00, mcADD);
      chk({tag, "_exec_norsp"}, {rsp1_valid, rsp0_valid}, 0);
      chk({tag, "_alu_in"}, {alu_a, alu_b, alu_op}, {a, b, op});
      expect_rsp(tag, p, alu_eval(a, b, op));
      chk({tag, "_done"}, {rsp1_valid, rsp0_valid}, 0);
   endtask

   // Reference model state for the randomized run
   logic [10:0] sb_q[$];
   int          busy, age, last, n_acc, n_rsp, cyc, wait0, wait1;

   task automatic cycle6(input bit gen);
      logic er0, er1, own, rsp_hs, acc0, acc1;
      int   p;
      if (gen) begin
         if (!req0_valid) begin
            if ($urandom_range(0, 2) == 0)
               drive_req(0, 1'b1, 8'($urandom), 8'($urandom), 3'($urandom));
         end else if (busy != 0 && $urandom_range(0, 15) == 0) begin
            drive_req(0, 1'b0, 8'h00, 8'h00, mcADD);
            wait0 = 0;
         end
         if (!req1_valid) begin
            if ($urandom_range(0, 2) == 0)
               drive_req(1, 1'b1, 8'($urandom), 8'($urandom), 3'($urandom));
         end else if (busy != 0 && $urandom_range(0, 15) == 0) begin
            drive_req(1, 1'b0, 8'h00, 8'h00, mcADD);
            wait1 = 0;
         end
         rsp0_ready = 1'($urandom_range(0, 1));
         rsp1_ready = 1'($urandom_range(0, 1));
      end else begin
         drive_req(0, 1'b0, 8'h00, 8'h00, mcADD);
         drive_req(1, 1'b0, 8'h00, 8'h00, mcADD);
         rsp0_ready = 1'b1;
         rsp1_ready = 1'b1;
      end
      #1;
      er0 = (busy == 0) && req0_valid && (!req1_valid || last == 1);
      er1 = (busy == 0) && req1_valid && (!req0_valid || last == 0);
      chk("t6_ready0", req0_ready, er0);
      chk("t6_ready1", req1_ready, er1);
      own    = (sb_q.size() > 0) ? sb_q[0][10] : 1'b0;
      rsp_hs = 1'b0;
      if (busy != 0 && age >= 2) begin
         chk("t6_rspv", {rsp1_valid, rsp0_valid}, own ? 2'b10 : 2'b01);
         chk("t6_data", {rsp_out, rsp_eq, rsp_lt}, sb_q[0][9:0]);
         rsp_hs = own ? rsp1_ready : rsp0_ready;
      end else begin
         chk("t6_rspv_quiet", {rsp1_valid, rsp0_valid}, 0);
      end
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      p    = acc0 ? 0 : 1;
      if (acc0 || acc1) begin
         if (p == 0) begin
            sb_q.push_back({1'b0, alu_eval(req0_a, req0_b, req0_op)});
            wait0 = 0;
            if (req1_valid) wait1++;
            chk("t6_starve1", wait1 <= 1, 1);
         end else begin
            sb_q.push_back({1'b1, alu_eval(req1_a, req1_b, req1_op)});
            wait1 = 0;
            if (req0_valid) wait0++;
            chk("t6_starve0", wait0 <= 1, 1);
         end
         n_acc++;
      end
      tick();
      cyc++;
      if (rsp_hs) begin
         busy = 0;
         void'(sb_q.pop_front());
         n_rsp++;
      end
      if (acc0 || acc1) begin
         busy = 1;
         age  = 1;
         last = p;
         drive_req(p, 1'b0, 8'h00, 8'h00, mcADD);
      end else if (busy != 0) begin
         age++;
      end
   endtask

   initial begin
      // Reset state, then a lone req0 add
      Reset = 1'b1;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      drive_req(0, 1'b1, 8'h05, 8'h03, mcADD);
      drive_req(1, 1'b0, 8'h00, 8'h00, mcADD);
      tick();
      chk("t1_rst_ready", {req1_ready, req0_ready}, 0);
      chk("t1_rst_rspv", {rsp1_valid, rsp0_valid}, 0);
      chk("t1_rst_res", {rsp_out, rsp_eq, rsp_lt}, 0);
      chk("t1_rst_alu", {alu_a, alu_b, alu_op}, 0);
      Reset = 1'b0;
      run_one("t1_add", 0, 8'h05, 8'h03, mcADD);

      // Contention from reset: req0 first, then alternation
      do_reset();
      drive_req(0, 1'b1, 8'h10, 8'h01, mcSUB);
      drive_req(1, 1'b1, 8'hF0, 8'h3C, mcAND);
      #1;
      chk("t2_tie_ready", {req1_ready, req0_ready}, 2'b01);
      tick();
      drive_req(0, 1'b0, 8'h00, 8'h00, mcADD);
      expect_rsp("t2_sub", 0, alu_eval(8'h10, 8'h01, mcSUB));
      chk("t2_sub_value", rsp_out, 8'h0F);
      chk("t2_next_ready", {req1_ready, req0_ready}, 2'b10);
      tick();
      drive_req(1, 1'b1, 8'hAA, 8'h55, mcXOR);
      drive_req(0, 1'b1, 8'h0F, 8'hF0, mcOR);
      expect_rsp("t2_and", 1, alu_eval(8'hF0, 8'h3C, mcAND));
      chk("t2_and_value", rsp_out, 8'h30);
      chk("t2_alt_ready", {req1_ready, req0_ready}, 2'b01);
      tick();
      drive_req(0, 1'b0, 8'h00, 8'h00, mcADD);
      expect_rsp("t2_or", 0, alu_eval(8'h0F, 8'hF0, mcOR));
      chk("t2_alt2_ready", {req1_ready, req0_ready}, 2'b10);
      tick();
      drive_req(1, 1'b0, 8'h00, 8'h00, mcADD);
      expect_rsp("t2_xor", 1, alu_eval(8'hAA, 8'h55, mcXOR));

      // Back-pressure on the response side
      do_reset();
      drive_req(0, 1'b1, 8'h33, 8'h44, mcADD);
      tick();
      drive_req(0, 1'b1, 8'h01, 8'h02, mcADD);
      drive_req(1, 1'b1, 8'h12, 8'h34, mcSUB);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_rspv", {rsp1_valid, rsp0_valid}, 2'b01);
         chk("t3_hold_out", {rsp_out, rsp_eq, rsp_lt}, alu_eval(8'h33, 8'h44, mcADD));
         chk("t3_hold_ready", {req1_ready, req0_ready}, 0);
         tick();
      end
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      chk("t3_release_ready", {req1_ready, req0_ready}, 2'b10);
      tick();
      drive_req(1, 1'b0, 8'h00, 8'h00, mcADD);
      expect_rsp("t3_req1", 1, alu_eval(8'h12, 8'h34, mcSUB));
      chk("t3_req0_ready", {req1_ready, req0_ready}, 2'b01);
      tick();
      drive_req(0, 1'b0, 8'h00, 8'h00, mcADD);
      expect_rsp("t3_req0", 0, alu_eval(8'h01, 8'h02, mcADD));

      // Wrap, shifts and flag pass-through
      do_reset();
      run_one("t4_wrap", 0, 8'hFF, 8'h01, mcADD);
      chk("t4_wrap_value", rsp_out, 8'h00);
      run_one("t4_lsl", 1, 8'h81, 8'h01, mcLSL);
      chk("t4_lsl_value", rsp_out, 8'h02);
      run_one("t4_lsr", 0, 8'h80, 8'h07, mcLSR);
      chk("t4_lsr_value", rsp_out, 8'h01);
      run_one("t4_eq", 1, 8'h5A, 8'h5A, mcSUB);
      run_one("t4_lt", 0, 8'h03, 8'h09, mcNOT);

      // Reset during EXEC
      do_reset();
      drive_req(0, 1'b1, 8'h11, 8'h22, mcADD);
      tick();
      drive_req(0, 1'b1, 8'h01, 8'h01, mcADD);
      drive_req(1, 1'b1, 8'h02, 8'h02, mcADD);
      Reset = 1'b1;
      tick();
      chk("t5e_ready", {req1_ready, req0_ready}, 0);
      chk("t5e_rspv", {rsp1_valid, rsp0_valid}, 0);
      chk("t5e_res", {rsp_out, rsp_eq, rsp_lt}, 0);
      chk("t5e_alu", {alu_a, alu_b, alu_op}, 0);
      Reset = 1'b0;
      #1;
      chk("t5e_tie", {req1_ready, req0_ready}, 2'b01);

      // Reset during RESP
      do_reset();
      drive_req(0, 1'b1, 8'h11, 8'h22, mcADD);
      tick();
      drive_req(0, 1'b0, 8'h00, 8'h00, mcADD);
      tick();
      chk("t5r_in_resp", {rsp1_valid, rsp0_valid}, 2'b01);
      drive_req(0, 1'b1, 8'h01, 8'h01, mcADD);
      drive_req(1, 1'b1, 8'h02, 8'h02, mcADD);
      Reset = 1'b1;
      tick();
      chk("t5r_rspv", {rsp1_valid, rsp0_valid}, 0);
      chk("t5r_res", {rsp_out, rsp_eq, rsp_lt}, 0);
      chk("t5r_alu", {alu_a, alu_b, alu_op}, 0);
      Reset = 1'b0;
      #1;
      chk("t5r_tie", {req1_ready, req0_ready}, 2'b01);

      // Randomized run against the scoreboard
      do_reset();
      busy = 0; age = 0; last = 1; n_acc = 0; n_rsp = 0; cyc = 0; wait0 = 0; wait1 = 0;
      while (n_acc < 2000 && cyc < 30000) cycle6(1'b1);
      chk("t6_budget", n_acc >= 2000, 1);
      for (int j = 0; j < 10 && busy != 0; j++) cycle6(1'b0);
      chk("t6_drained", busy, 0);
      chk("t6_sb_empty", sb_q.size(), 0);
      chk("t6_one_rsp_each", n_rsp, n_acc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
